// File: rtl/kronos_counter_pkg.sv
// Shared types for the performance-counter CSR controller: FSM states,
// well-known counter indices and the latched request record.
package kronos_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR,
        RESP
    } ctrl_state_e;

    localparam int CTR_CYCLE   = 0;
    localparam int CTR_INSTRET = 1;

    // Wide enough for NUM_CTR up to 29 plus the inhibit slot and out-of-range codes.
    localparam int MAX_SELW = 5;

    typedef struct packed {
        logic                we;
        logic                hi;
        logic [MAX_SELW-1:0] sel;
        logic [31:0]         wdata;
    } ctr_req_t;

endpackage

// File: rtl/kronos_counter64.sv
// 64b event counter with a registered carry from the low word into the high
// word; count_vld drops for the one cycle in which that carry is in flight.
module kronos_counter64 #(
    parameter bit EN_COUNTERS    = 1'b1,
    parameter bit EN_COUNTERS64B = 1'b1
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        incr,
    input  logic        load_low,
    input  logic        load_high,
    input  logic [31:0] load_data,
    output logic [63:0] count,
    output logic        count_vld
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry_q, carry_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        carry_d = 1'b0;

        // The counter pauses while either word is being loaded.
        if (load_low) begin
            lo_d = load_data;
        end else if (incr && !load_high) begin
            {carry_d, lo_d} = {1'b0, lo_q} + 33'd1;
        end

        if (load_high) begin
            hi_d = load_data;
        end else if (carry_q) begin
            hi_d = hi_q + 32'd1;
        end

        if (!EN_COUNTERS64B) begin
            hi_d    = '0;
            carry_d = 1'b0;
        end
        if (!EN_COUNTERS) begin
            lo_d    = '0;
            hi_d    = '0;
            carry_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            lo_q    <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
        end
    end

    assign count     = {hi_q, lo_q};
    assign count_vld = ~carry_q;

endmodule

// File: rtl/kronos_counter_ctrl.sv
// CSR-side controller for a bank of 64b performance counters: inhibit gating
// and a serialised 32b read/write port that never returns a torn high word.
module kronos_counter_ctrl
    import kronos_counter_pkg::*;
#(
    parameter int NUM_CTR        = 3,
    parameter bit EN_COUNTERS    = 1'b1,
    parameter bit EN_COUNTERS64B = 1'b1,
    parameter int SELW           = $clog2(NUM_CTR + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CTR-1:0] ctr_event,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic               req_we,
    input  logic               req_hi,
    input  logic [SELW-1:0]    req_sel,
    input  logic [31:0]        req_wdata,
    output logic               rsp_vld,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err
);

    ctrl_state_e        state_q, state_d;
    ctr_req_t           req_q, req_d;
    logic [NUM_CTR-1:0] inhibit_q, inhibit_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [63:0]        counts [NUM_CTR];
    logic [NUM_CTR-1:0] count_vld;
    logic [NUM_CTR-1:0] incr;
    logic [NUM_CTR-1:0] load_low;
    logic [NUM_CTR-1:0] load_high;
    logic               rstz;

    logic [NUM_CTR-1:0] sel_onehot;
    logic [63:0]        sel_count;
    logic               sel_vld;
    logic               sel_inh;
    logic               sel_bad;

    assign rstz    = ~rst;
    assign incr    = ctr_event & ~inhibit_q;
    assign req_rdy = (state_q == IDLE) & ~rst;
    assign rsp_vld = (state_q == RESP);

    always_comb begin
        sel_onehot = '0;
        sel_count  = '0;
        sel_vld    = 1'b0;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (req_q.sel == MAX_SELW'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_count     = counts[i];
                sel_vld       = count_vld[i];
            end
        end
        sel_inh = (req_q.sel == MAX_SELW'(NUM_CTR));
        sel_bad = (req_q.sel >  MAX_SELW'(NUM_CTR));
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        inhibit_d = inhibit_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        load_low  = '0;
        load_high = '0;

        unique case (state_q)
            IDLE: begin
                if (req_vld) begin
                    req_d.we    = req_we;
                    req_d.hi    = req_hi;
                    req_d.sel   = MAX_SELW'(req_sel);
                    req_d.wdata = req_wdata;
                    state_d     = req_we ? WR : RD_WAIT;
                end
            end
            RD_WAIT: begin
                err_d = 1'b0;
                if (sel_bad) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (sel_inh) begin
                    rdata_d = 32'(inhibit_q);
                    state_d = RESP;
                end else if (sel_vld) begin
                    // Waiting on count_vld keeps a high-word read from catching a carry in flight.
                    rdata_d = req_q.hi ? sel_count[63:32] : sel_count[31:0];
                    state_d = RESP;
                end
            end
            WR: begin
                rdata_d = '0;
                err_d   = sel_bad;
                if (req_q.we) begin
                    if (sel_inh) begin
                        inhibit_d = req_q.wdata[NUM_CTR-1:0];
                    end
                    load_low  = req_q.hi ? '0 : sel_onehot;
                    load_high = req_q.hi ? sel_onehot : '0;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            inhibit_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            inhibit_q <= inhibit_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
        kronos_counter64 #(
            .EN_COUNTERS    (EN_COUNTERS),
            .EN_COUNTERS64B (EN_COUNTERS64B)
        ) u_ctr (
            .clk       (clk),
            .rstz      (rstz),
            .incr      (incr[i]),
            .load_low  (load_low[i]),
            .load_high (load_high[i]),
            .load_data (req_q.wdata),
            .count     (counts[i]),
            .count_vld (count_vld[i])
        );
    end

endmodule

// File: tb/tb_kronos_counter_ctrl.sv
// Directed self-checking bench for kronos_counter_ctrl (NUM_CTR = 4 so that
// an out-of-range selector is encodable).
module tb_kronos_counter_ctrl;

    localparam int NUM_CTR = 4;
    localparam int SELW    = 3;
    localparam int INH     = NUM_CTR;
    localparam int BAD     = NUM_CTR + 1;

    logic               clk;
    logic               rst;
    logic [NUM_CTR-1:0] ctr_event;
    logic               req_vld;
    logic               req_rdy;
    logic               req_we;
    logic               req_hi;
    logic [SELW-1:0]    req_sel;
    logic [31:0]        req_wdata;
    logic               rsp_vld;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    kronos_counter_ctrl #(
        .NUM_CTR        (NUM_CTR),
        .EN_COUNTERS    (1'b1),
        .EN_COUNTERS64B (1'b1),
        .SELW           (SELW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctr_event (ctr_event),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_we    (req_we),
        .req_hi    (req_hi),
        .req_sel   (req_sel),
        .req_wdata (req_wdata),
        .rsp_vld   (rsp_vld),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the response cycle.
    task automatic do_req(input logic we, input logic hi, input int sel, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        req_vld   = 1'b1;
        req_we    = we;
        req_hi    = hi;
        req_sel   = SELW'(sel);
        req_wdata = wdata;
        check("rdy_idle", 32'(req_rdy), 32'd1);
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_vld   = 1'b0;
                req_wdata = '0;
            end
            check("rdy_busy", 32'(req_rdy), 32'd0);
            if (rsp_vld) begin
                lat   = n;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
        if (lat == 0) check("rsp_timeout", 32'(rsp_vld), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic hi, input int sel,
                          input logic [31:0] exp, input int exp_lat);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        @(negedge clk);
        do_req(1'b0, hi, sel, 32'd0, rdata, err, lat);
        check(tag, rdata, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic wr_chk(input string tag, input logic hi, input int sel, input logic [31:0] wdata);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        @(negedge clk);
        do_req(1'b1, hi, sel, wdata, rdata, err, lat);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat;

        rst       = 1'b1;
        ctr_event = '0;
        req_vld   = 1'b0;
        req_we    = 1'b0;
        req_hi    = 1'b0;
        req_sel   = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy_low", 32'(req_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", 32'(req_rdy), 32'd1);
        check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);

        // 1: plain read right after reset
        rd_chk("t1_c0_lo", 1'b0, 0, 32'd0, 2);

        // 2: wrap the low word in the accept cycle; the high read must stall one cycle
        wr_chk("t2_wr", 1'b0, 0, 32'hFFFF_FFFF);
        @(negedge clk);
        ctr_event = 4'b0001;
        do_req(1'b0, 1'b1, 0, 32'd0, rdata, err, lat);
        ctr_event = '0;
        check("t2_c0_hi", rdata, 32'h0000_0001);
        check("t2_c0_hi_lat", 32'(lat), 32'd3);
        check("t2_c0_hi_err", 32'(err), 32'd0);
        rd_chk("t2_c0_lo", 1'b0, 0, 32'd2, 2);

        // 3: inhibit counter 1, run all events for 10 cycles
        wr_chk("t3_inh", 1'b0, INH, 32'h0000_0002);
        @(negedge clk);
        ctr_event = 4'b1111;
        repeat (10) @(negedge clk);
        ctr_event = '0;
        rd_chk("t3_c0_lo", 1'b0, 0, 32'd12, 2);
        rd_chk("t3_c0_hi", 1'b1, 0, 32'd1, 2);
        rd_chk("t3_c1_lo", 1'b0, 1, 32'd0, 2);
        rd_chk("t3_c2_lo", 1'b0, 2, 32'd10, 2);
        rd_chk("t3_c3_lo", 1'b0, 3, 32'd10, 2);
        rd_chk("t3_inh_rd", 1'b0, INH, 32'h0000_0002, 2);

        // 4: high-word write while counter 1 is counting; one increment is lost
        wr_chk("t4_inh_clr", 1'b0, INH, 32'd0);
        @(negedge clk);
        ctr_event = 4'b0010;
        do_req(1'b1, 1'b1, 1, 32'h1234_5678, rdata, err, lat);
        ctr_event = '0;
        check("t4_wr_lat", 32'(lat), 32'd2);
        check("t4_wr_err", 32'(err), 32'd0);
        rd_chk("t4_c1_hi", 1'b1, 1, 32'h1234_5678, 2);
        rd_chk("t4_c1_lo", 1'b0, 1, 32'd1, 2);
        rd_chk("t4_c0_lo", 1'b0, 0, 32'd12, 2);

        // 5: out-of-range selector
        @(negedge clk);
        do_req(1'b0, 1'b0, BAD, 32'd0, rdata, err, lat);
        check("t5_rd_err", 32'(err), 32'd1);
        check("t5_rd_rdata", rdata, 32'd0);
        check("t5_rd_lat", 32'(lat), 32'd2);
        @(negedge clk);
        do_req(1'b1, 1'b0, BAD, 32'hFFFF_FFFF, rdata, err, lat);
        check("t5_wr_err", 32'(err), 32'd1);
        check("t5_wr_rdata", rdata, 32'd0);
        check("t5_wr_lat", 32'(lat), 32'd2);
        rd_chk("t5_inh", 1'b0, INH, 32'd0, 2);
        rd_chk("t5_c0_lo", 1'b0, 0, 32'd12, 2);
        rd_chk("t5_c2_lo", 1'b0, 2, 32'd10, 2);

        // plain write/readback of both words
        wr_chk("wr_c2_lo", 1'b0, 2, 32'hDEAD_BEEF);
        rd_chk("rd_c2_lo", 1'b0, 2, 32'hDEAD_BEEF, 2);
        wr_chk("wr_c0_hi", 1'b1, 0, 32'hAABB_CCDD);
        rd_chk("rd_c0_hi", 1'b1, 0, 32'hAABB_CCDD, 2);

        // 6: reset while a read sits in RD_WAIT
        wr_chk("t6_inh", 1'b0, INH, 32'h0000_0005);
        @(negedge clk);
        req_vld = 1'b1;
        req_we  = 1'b0;
        req_hi  = 1'b0;
        req_sel = SELW'(0);
        @(negedge clk);
        req_vld = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("t6_no_rsp", 32'(rsp_vld), 32'd0);
        check("t6_rdy_in_rst", 32'(req_rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rdy", 32'(req_rdy), 32'd1);
        check("t6_no_rsp2", 32'(rsp_vld), 32'd0);
        rd_chk("t6_c0_lo", 1'b0, 0, 32'd0, 2);
        rd_chk("t6_c0_hi", 1'b1, 0, 32'd0, 2);
        rd_chk("t6_c1_hi", 1'b1, 1, 32'd0, 2);
        rd_chk("t6_c2_lo", 1'b0, 2, 32'd0, 2);
        rd_chk("t6_inh", 1'b0, INH, 32'd0, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/kronos_counter_ctrl.md
Name: kronos_counter_ctrl

Overview:
CSR-side controller for a bank of NUM_CTR 64b performance counters (index 0 = cycle, 1 = instret, 2+ = hpm).
- Instantiates the counters.
- Gates their increment events through an inhibit register (mcountinhibit-style).
- Serialises 32b CSR read/write requests onto the selected counter's low or high word over a single valid/ready request port.
- Holds high-word reads until the staggered carry has settled, so a read never returns a torn value.

Parameters:
NUM_CTR, 3, number of 64b counters in the bank (1..29).
EN_COUNTERS, 1, 0 ties all counts to zero; requests still complete.
EN_COUNTERS64B, 1, 0 makes the high words read as zero and ignores high-word writes.
SELW, $clog2(NUM_CTR+1), derived width of the selector.

Ports:
clk  in  1  clock; the only clock.
rst  in  1  reset; synchronous, active-high.
ctr_event  in  NUM_CTR  per-counter increment event, one increment per cycle when high.
req_vld  in  1  request valid.
req_rdy  out  1  request ready.
req_we  in  1  1 = write, 0 = read.
req_hi  in  1  selects the high word [63:32]; otherwise [31:0].
req_sel  in  SELW  counter index; value NUM_CTR selects the inhibit register.
req_wdata  in  32  write data.
rsp_vld  out  1  response valid, one-cycle pulse; no backpressure.
rsp_rdata  out  32  read data; 0 for writes.
rsp_err  out  1  selector out of range; qualified by rsp_vld.

Behaviour:
- Reset (1 cycle, synchronous):
  - State returns to IDLE from any state; an in-flight request is dropped with no response.
  - rsp_vld, rsp_rdata, rsp_err and inhibit clear to 0.
  - All counters clear to 0; counter rstz = ~rst.
  - req_rdy = 0 while rst = 1.
- States: IDLE, RD_WAIT, WR, RESP.
- IDLE:
  - req_rdy = 1.
  - On req_vld & req_rdy, latch we/hi/sel/wdata; go to RD_WAIT (read) or WR (write).
  - Request fields need only be stable in the accept cycle.
- RD_WAIT:
  - If sel >= NUM_CTR+1: rsp_err = 1, rdata = 0, go to RESP.
  - If sel == NUM_CTR: rdata = zero-extended inhibit, go to RESP.
  - Else, if count_vld of the selected counter: capture the selected word into rdata, go to RESP.
  - Else stay. The stall is at most 1 cycle.
- WR:
  - For one cycle, drive load_low (hi = 0) or load_high (hi = 1) with load_data = wdata on the selected counter only.
  - sel == NUM_CTR: inhibit <= wdata[NUM_CTR-1:0], effective from the next cycle.
  - Out-of-range sel: no side effect, rsp_err = 1.
  - Go to RESP.
- RESP: rsp_vld = 1 for exactly one cycle, then IDLE. req_rdy = 0 in every state except IDLE.
- Latency from accept cycle C:
  - Read: rsp_vld at C+2 (C+3 if stalled).
  - Write: rsp_vld at C+2; the load takes effect at C+2.
  - Throughput: one request per 3 cycles minimum.
- Increment gating: incr[i] = ctr_event[i] & ~inhibit[i]. Increments on a counter being loaded are lost, because the counter pauses during a load. Other counters keep counting during any request.
- Write of the low word while a carry is pending: the pending carry is applied to the high word after the load completes. This is counter behaviour and is not masked.
- Wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 = 0. A high-word read returns the new value only after count_vld.
- EN_COUNTERS = 0: reads return 0, writes to counters are dropped, inhibit stays writable.

Decomposition:
- Package kronos_counter_pkg:
  - ctrl_state_e enum (IDLE, RD_WAIT, WR, RESP).
  - CTR_CYCLE = 0 and CTR_INSTRET = 1 index constants.
  - ctr_req_t struct (we, hi, sel, wdata).
- Sub-module: NUM_CTR instances of kronos_counter64 in a generate loop; the controller FSM stays in this module.

Test Plan:
1. After reset, read sel 0 low with ctr_event[0] = 0 -> rsp_vld at C+2, rdata = 0, rsp_err = 0; req_rdy = 0 during C+1 and C+2.
2. Write sel 0 low = 0xFFFF_FFFF, then ctr_event[0] held high, then read high immediately after the wrap -> RD_WAIT stalls 1 cycle, rdata = 0x0000_0001, never 0.
3. Write inhibit (sel = NUM_CTR) = 0b010 with events high for 10 cycles -> counter 1 unchanged, counters 0 and 2 advance by 10; inhibit readback = 0x2.
4. Write sel 1 high = 0x1234_5678 while ctr_event[1] is high -> the counter reads 0x1234_5678_xxxx_xxxx; the low word skipped exactly one increment.
5. Read or write with sel = NUM_CTR+1 -> rsp_vld with rsp_err = 1, rdata = 0, no counter or inhibit change.
6. Assert rst in RD_WAIT -> no rsp_vld; next cycle all counts and inhibit are 0 and req_rdy = 1.
